valid_bit_packer: RTL and testbench

VALID_BIT_PACKER -- requirements
Module: valid_bit_packer

---
 rtl/valid_bit_packer.sv | 171 +++++++++++++++++
 tb/tb_valid_bit_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/valid_bit_packer.sv
// valid_bit_packer
//   Collects a serial stream of valid-qualified bits into WIDTH-bit words,
//   LSB first, and queues completed words in a small DEPTH-entry FIFO for a
//   ready/valid consumer.
//
// Parameters
//   WIDTH  bits per packed word (2..32)
//   DEPTH  output FIFO entries (1..8)
//
// Ports
//   clk           rising-edge clock for all state
//   reset         asynchronous, active-high reset
//   io_in_valid   upstream bit is present
//   io_in_bits    serial data bit
//   io_in_ready   block accepts a bit this cycle
//   io_flush      discard the partially assembled word
//   io_out_valid  FIFO head word is valid
//   io_out_bits   FIFO head word (0 when the FIFO is empty)
//   io_out_ready  downstream accepts the head word
//   io_count      bits accumulated in the current partial word
//   io_occupancy  words held in the FIFO
module valid_bit_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_in_valid,
  input  logic                       io_in_bits,
  output logic                       io_in_ready,
  input  logic                       io_flush,
  output logic                       io_out_valid,
  output logic [WIDTH-1:0]           io_out_bits,
  input  logic                       io_out_ready,
  output logic [$clog2(WIDTH)-1:0]   io_count,
  output logic [$clog2(DEPTH+1)-1:0] io_occupancy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  // A single-entry FIFO still needs a 1-bit pointer to keep the ports legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  // Packing state
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;

  // FIFO state
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;

  // Handshake decode
  logic             at_last;
  logic             fifo_full;
  logic             in_ready;
  logic             in_fire;
  logic             push;
  logic             out_valid;
  logic             pop;
  logic [WIDTH-1:0] merged_word;
  logic [DEPTH-1:0] entry_we;

  always_comb begin
    at_last   = (count_reg == LAST_COUNT);
    fifo_full = (occ_reg == FULL_OCC);
    // Ready only drops when the next bit would complete a word with nowhere
    // to put it. Built from registered state alone, so there is no
    // combinational path from io_out_ready, even though a same-cycle pop
    // would have made room.
    in_ready  = !(at_last && fifo_full);
    in_fire   = io_in_valid && in_ready && !io_flush;
    push      = in_fire && at_last;
    out_valid = (occ_reg != '0);
    pop       = out_valid && io_out_ready;
    // Current partial word with the incoming bit dropped into slot count.
    merged_word = shift_reg | (WIDTH'(io_in_bits) << count_reg);
  end

  // Bit counter and shift register
  always_comb begin
    count_next = count_reg;
    shift_next = shift_reg;
    if (io_flush) begin
      count_next = '0;
      shift_next = '0;
    end else if (in_fire) begin
      if (at_last) begin
        // Word leaves through push; start the next one clean.
        count_next = '0;
        shift_next = '0;
      end else begin
        count_next = count_reg + 1'b1;
        shift_next = merged_word;
      end
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    end

    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  // Per-entry write enables; a push is never issued while full, so the
  // entry under the write pointer is always free.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      shift_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      count_reg  <= count_next;
      shift_reg  <= shift_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Word storage lives in flops so that reset can clear it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) begin
          mem_reg[i] <= merged_word;
        end
      end
    end
  end

  // Outputs. The head word is masked to zero while empty so the reset and
  // idle values are well defined.
  assign io_in_ready  = in_ready;
  assign io_out_valid = out_valid;
  assign io_out_bits  = out_valid ? mem_reg[rd_ptr_reg] : '0;
  assign io_count     = count_reg;
  assign io_occupancy = occ_reg;

endmodule

// File: tb/tb_valid_bit_packer.sv
// Testbench for valid_bit_packer (WIDTH=8, DEPTH=2).
// A reference model tracks count, partial word and the expected FIFO queue;
// a negedge scoreboard compares DUT status every cycle and compares each
// popped word with the queue head. Directed table vectors and hand-written
// sequences cover packing, flush, backpressure, concurrent push/pop and async
// reset, followed by a long random run.
module tb_valid_bit_packer;

  logic       clk;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_bits;
  logic       io_in_ready;
  logic       io_flush;
  logic       io_out_valid;
  logic [7:0] io_out_bits;
  logic       io_out_ready;
  logic [2:0] io_count;
  logic [1:0] io_occupancy;

  valid_bit_packer #(.WIDTH(8), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_in_ready  (io_in_ready),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_out_ready (io_out_ready),
    .io_count     (io_count),
    .io_occupancy (io_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  logic [2:0] m_count;
  logic [7:0] m_shift;
  int         m_pushes = 0;
  int         dut_pops = 0;
  bit         sb_on = 0;

  always @(posedge clk or posedge reset) begin : model
    int         sz;
    logic       rdy;
    logic       fire;
    logic [7:0] tmp;
    if (reset) begin
      m_count <= 3'd0;
      m_shift <= 8'd0;
      q.delete();
    end else begin
      sz   = q.size();
      rdy  = !(m_count == 3'd7 && sz == 2);
      fire = io_in_valid && rdy && !io_flush;
      if (io_out_ready && sz != 0) tmp = q.pop_front();
      if (io_flush) begin
        m_count <= 3'd0;
        m_shift <= 8'd0;
      end else if (fire) begin
        if (m_count == 3'd7) begin
          tmp = m_shift;
          tmp[7] = io_in_bits;
          q.push_back(tmp);
          m_pushes++;
          m_count <= 3'd0;
          m_shift <= 8'd0;
        end else begin
          m_shift[m_count] <= io_in_bits;
          m_count <= m_count + 3'd1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && sb_on) begin
      check("sb_out_valid", io_out_valid, q.size() != 0);
      check("sb_in_ready", io_in_ready, !(m_count == 3'd7 && q.size() == 2));
      check("sb_count", io_count, m_count);
      check("sb_occupancy", io_occupancy, q.size());
      if (io_out_valid && io_out_ready) begin
        dut_pops++;
        if (q.size() != 0) check("sb_pop_word", io_out_bits, q[0]);
      end
    end
  end

  // Drive inputs just after a rising edge, then advance to 1 time unit past
  // the next rising edge so the caller sees the updated state.
  task automatic step(input logic v, input logic b, input logic f, input logic r);
    io_in_valid  = v;
    io_in_bits   = b;
    io_flush     = f;
    io_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] bits;   // bit k fed on the k-th accepted cycle
    int         junk;   // bits fed and then flushed before the word
    logic [7:0] exp;    // expected packed word
  } vec_t;

  vec_t        vt[6];
  logic [23:0] stream;
  logic [15:0] cs;
  logic [7:0]  w;
  int          pops0, pushes0;

  initial begin
    vt[0] = '{8'b01001101, 0, 8'h4D};
    vt[1] = '{8'hFF,       0, 8'hFF};
    vt[2] = '{8'h00,       2, 8'h00};
    vt[3] = '{8'hA5,       5, 8'hA5};
    vt[4] = '{8'h80,       7, 8'h80};
    vt[5] = '{8'h01,       3, 8'h01};

    reset = 1'b0;
    io_in_valid = 1'b0; io_in_bits = 1'b0; io_flush = 1'b0; io_out_ready = 1'b1;

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_count", io_count, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_in_ready", io_in_ready, 1);
    check("rst_occupancy", io_occupancy, 0);
    check("rst_out_bits", io_out_bits, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    sb_on = 1;

    // ---- table vectors: basic pack and flush-then-pack ----
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vt[i].junk; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
      if (vt[i].junk > 0) begin
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_count", io_count, 0);
        check("flush_no_push", io_occupancy, 0);
      end
      for (int k = 0; k < 8; k++) begin
        step(1'b1, vt[i].bits[k], 1'b0, 1'b1);
        if (k < 7) check("no_early_word", io_out_valid, 0);
      end
      check("word_valid", io_out_valid, 1);
      check("word_bits", io_out_bits, vt[i].exp);
      check("count_wrap", io_count, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("single_pulse", io_out_valid, 0);
    end

    // ---- backpressure: 24 bits with the consumer stalled ----
    stream = {8'h5A, 8'hC3, 8'h3C};
    for (int i = 0; i < 23; i++) step(1'b1, stream[i], 1'b0, 1'b0);
    check("bp_occupancy", io_occupancy, 2);
    check("bp_count", io_count, 7);
    check("bp_in_ready", io_in_ready, 0);
    check("bp_head", io_out_bits, 8'h3C);
    step(1'b1, stream[23], 1'b0, 1'b0);
    check("bp_bit_held", io_count, 7);
    step(1'b1, stream[23], 1'b0, 1'b1);
    check("bp_pop1_occ", io_occupancy, 1);
    check("bp_pop1_head", io_out_bits, 8'hC3);
    check("bp_pop1_count", io_count, 7);
    check("bp_ready_back", io_in_ready, 1);
    step(1'b1, stream[23], 1'b0, 1'b1);
    check("bp_pop2_occ", io_occupancy, 1);
    check("bp_third_word", io_out_bits, 8'h5A);
    check("bp_count_zero", io_count, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", io_out_valid, 0);

    // ---- concurrent push and pop ----
    cs = {8'h69, 8'h96};
    for (int i = 0; i < 15; i++) step(1'b1, cs[i], 1'b0, 1'b0);
    check("cc_occ_before", io_occupancy, 1);
    check("cc_head_before", io_out_bits, 8'h96);
    step(1'b1, cs[15], 1'b0, 1'b1);
    check("cc_occ_after", io_occupancy, 1);
    check("cc_head_after", io_out_bits, 8'h69);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // ---- async reset mid-word with a stored word ----
    for (int i = 0; i < 12; i++) step(1'b1, i[0], 1'b0, 1'b0);
    check("ar_pre_occ", io_occupancy, 1);
    check("ar_pre_count", io_count, 4);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", io_out_valid, 0);
    check("ar_count", io_count, 0);
    check("ar_in_ready", io_in_ready, 1);
    check("ar_occupancy", io_occupancy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    w = 8'hE7;
    for (int k = 0; k < 8; k++) step(1'b1, w[k], 1'b0, 1'b1);
    check("ar_resume_word", io_out_bits, 8'hE7);
    check("ar_resume_valid", io_out_valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // ---- random traffic ----
    pops0 = dut_pops;
    pushes0 = m_pushes;
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rnd_drained", io_occupancy, 0);
    check("rnd_word_total", dut_pops - pops0, m_pushes - pushes0);

    sb_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
